// File: rtl/driver_74lv165_chain.sv
// Scanner for daisy-chained 74LV165 PISO registers on CHANNELS parallel serial lines.
// Generates SH_LDn/RCLK, captures whole frames and debounces them over consecutive frames.
module driver_74lv165_chain #(
  parameter int CHANNELS        = 4,
  parameter int CHAIN_BITS      = 16,
  parameter int CLK_DIV         = 1,
  parameter int DEBOUNCE_FRAMES = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           cont_en,
  input  logic [CHANNELS-1:0]            QH,
  output logic                           SH_LDn,
  output logic                           RCLK,
  output logic                           busy,
  output logic [CHANNELS*CHAIN_BITS-1:0] raw_data,
  output logic [CHANNELS*CHAIN_BITS-1:0] data,
  output logic                           frame_done,
  output logic                           data_changed
);

  localparam int W        = CHANNELS * CHAIN_BITS;
  localparam int DIV_W    = $clog2(CLK_DIV + 1);
  localparam int BIT_W    = $clog2(CHAIN_BITS);
  localparam int STREAK_W = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST   = BIT_W'(CHAIN_BITS - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                half_q, half_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [W-1:0]        sreg_q, sreg_d;
  logic                sh_ldn_q, sh_ldn_d;
  logic                rclk_q, rclk_d;
  logic                busy_q, busy_d;
  logic [W-1:0]        raw_q, raw_d;
  logic [W-1:0]        data_q, data_d;
  logic [W-1:0]        cand_q, cand_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                frame_done_q, frame_done_d;
  logic                data_changed_q, data_changed_d;
  logic                half_end;
  logic [STREAK_W-1:0] streak_new;

  always_comb begin
    // NOTE: every _d gets a default first so no branch can leave a latch behind.
    state_d        = state_q;
    div_d          = div_q;
    half_d         = half_q;
    bit_d          = bit_q;
    sreg_d         = sreg_q;
    sh_ldn_d       = sh_ldn_q;
    rclk_d         = rclk_q;
    busy_d         = busy_q;
    raw_d          = raw_q;
    data_d         = data_q;
    cand_d         = cand_q;
    streak_d       = streak_q;
    frame_done_d   = 1'b0;
    data_changed_d = 1'b0;
    half_end       = (div_q == DIV_LAST);

    // Streak for the frame now sitting complete in sreg_q; saturates at the threshold.
    if (sreg_q == cand_q) begin
      streak_new = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
    end else begin
      streak_new = STREAK_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start || cont_en) begin
          state_d  = LOAD;
          sh_ldn_d = 1'b0;
          busy_d   = 1'b1;
          div_d    = '0;
          half_d   = 1'b0;
        end
      end

      LOAD: begin
        if (half_end) begin
          div_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d   = 1'b0;
            bit_d    = '0;
            state_d  = SHIFT;
            sh_ldn_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT: begin
        if (half_end) begin
          div_d = '0;
          if (!half_q) begin
            // Sample QH before raising RCLK so the chain shifts only after capture.
            half_d = 1'b1;
            rclk_d = 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
              sreg_d[c*CHAIN_BITS +: CHAIN_BITS] = {sreg_q[c*CHAIN_BITS +: CHAIN_BITS-1], QH[c]};
            end
          end else begin
            half_d = 1'b0;
            rclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d      = DONE;
              raw_d        = sreg_q;
              frame_done_d = 1'b1;
              cand_d       = sreg_q;
              streak_d     = streak_new;
              if (streak_new == STREAK_MAX && sreg_q != data_q) begin
                data_d         = sreg_q;
                data_changed_d = 1'b1;
              end
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      DONE: begin
        if (cont_en) begin
          state_d  = LOAD;
          sh_ldn_d = 1'b0;
          div_d    = '0;
          half_d   = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: flops update with <= so every register samples pre-edge values of the others.
  // NOTE: the shift registers are plain flops and are cleared on reset like all other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      div_q          <= '0;
      half_q         <= 1'b0;
      bit_q          <= '0;
      sreg_q         <= '0;
      sh_ldn_q       <= 1'b1;
      rclk_q         <= 1'b0;
      busy_q         <= 1'b0;
      raw_q          <= '0;
      data_q         <= '0;
      cand_q         <= '0;
      streak_q       <= '0;
      frame_done_q   <= 1'b0;
      data_changed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      half_q         <= half_d;
      bit_q          <= bit_d;
      sreg_q         <= sreg_d;
      sh_ldn_q       <= sh_ldn_d;
      rclk_q         <= rclk_d;
      busy_q         <= busy_d;
      raw_q          <= raw_d;
      data_q         <= data_d;
      cand_q         <= cand_d;
      streak_q       <= streak_d;
      frame_done_q   <= frame_done_d;
      data_changed_q <= data_changed_d;
    end
  end

  assign SH_LDn       = sh_ldn_q;
  assign RCLK         = rclk_q;
  assign busy         = busy_q;
  assign raw_data     = raw_q;
  assign data         = data_q;
  assign frame_done   = frame_done_q;
  assign data_changed = data_changed_q;

endmodule

// File: tb/tb_driver_74lv165_chain.sv
// Bench for driver_74lv165_chain: two instances (debounce 1 and 3) scan a behavioural 74LV165
// chain and are compared every cycle against a frame-timing model plus literal spot values.
module tb_driver_74lv165_chain;

  localparam int CH  = 2;
  localparam int CB  = 16;
  localparam int DIV = 2;
  localparam int W   = CH * CB;
  localparam int P   = 2 * DIV * (CB + 1) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cont_en = 1'b0;
  logic [CH-1:0] qh;

  logic sh_ldn_a, rclk_a, busy_a, fd_a, dc_a;
  logic sh_ldn_b, rclk_b, busy_b, fd_b, dc_b;
  logic [W-1:0] raw_a, data_a, raw_b, data_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  driver_74lv165_chain #(.CHANNELS(CH), .CHAIN_BITS(CB), .CLK_DIV(DIV), .DEBOUNCE_FRAMES(1)) dut_deb1 (
    .clk(clk), .reset(reset), .start(start), .cont_en(cont_en), .QH(qh),
    .SH_LDn(sh_ldn_a), .RCLK(rclk_a), .busy(busy_a), .raw_data(raw_a), .data(data_a),
    .frame_done(fd_a), .data_changed(dc_a)
  );

  driver_74lv165_chain #(.CHANNELS(CH), .CHAIN_BITS(CB), .CLK_DIV(DIV), .DEBOUNCE_FRAMES(3)) dut_deb3 (
    .clk(clk), .reset(reset), .start(start), .cont_en(cont_en), .QH(qh),
    .SH_LDn(sh_ldn_b), .RCLK(rclk_b), .busy(busy_b), .raw_data(raw_b), .data(data_b),
    .frame_done(fd_b), .data_changed(dc_b)
  );

  // 74LV165 chain per channel: async parallel load while SH_LDn low, shift on RCLK rise.
  logic [CB-1:0] pat  [CH];
  logic [CB-1:0] chip [CH];

  always @(posedge rclk_a or negedge sh_ldn_a) begin
    for (int c = 0; c < CH; c++) begin
      chip[c] <= !sh_ldn_a ? pat[c] : {chip[c][CB-2:0], 1'b0};
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) qh[c] = chip[c][CB-1];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: m_t is the cycle index inside the current frame, -1 when idle.
  int           m_t = -1;
  logic [W-1:0] m_pat = '0;
  logic [W-1:0] m_raw = '0;
  logic [W-1:0] m_data [2] = '{default: '0};
  logic [W-1:0] m_cand [2] = '{default: '0};
  int           m_streak [2] = '{default: 0};
  logic         m_dc [2] = '{default: 1'b0};

  function automatic int deb(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic exp_shldn(input int t);
    return !(t >= 0 && t < 2 * DIV);
  endfunction

  function automatic logic exp_rclk(input int t);
    int s;
    s = t - 2 * DIV;
    return (s >= 0) && (s < 2 * DIV * CB) && ((s % (2 * DIV)) >= DIV);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_t = -1;
        m_raw = '0;
        m_pat = '0;
        for (int i = 0; i < 2; i++) begin
          m_data[i] = '0; m_cand[i] = '0; m_streak[i] = 0; m_dc[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 2; i++) m_dc[i] = 1'b0;
        if (m_t < 0) begin
          if (start || cont_en) m_t = 0;
        end else if (m_t == P - 1) begin
          m_t = cont_en ? 0 : -1;
        end else begin
          if (m_t == 0) m_pat = {pat[1], pat[0]};
          m_t++;
          if (m_t == P - 1) begin
            m_raw = m_pat;
            for (int i = 0; i < 2; i++) begin
              if (m_pat == m_cand[i]) begin
                if (m_streak[i] < deb(i)) m_streak[i]++;
              end else begin
                m_cand[i] = m_pat;
                m_streak[i] = 1;
              end
              if (m_streak[i] == deb(i) && m_pat != m_data[i]) begin
                m_data[i] = m_pat;
                m_dc[i] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  int   fd_cnt = 0, dc_a_cnt = 0, dc_b_cnt = 0, rise_cnt = 0, ldn_low_cnt = 0, fd_cyc = 0;
  logic prev_rclk = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      check("sh_ldn_deb1", sh_ldn_a, exp_shldn(m_t));
      check("rclk_deb1",   rclk_a,   exp_rclk(m_t));
      check("busy_deb1",   busy_a,   m_t >= 0);
      check("fdone_deb1",  fd_a,     m_t == P - 1);
      check("dchg_deb1",   dc_a,     m_dc[0]);
      check("raw_deb1",    raw_a,    m_raw);
      check("data_deb1",   data_a,   m_data[0]);
      check("sh_ldn_deb3", sh_ldn_b, exp_shldn(m_t));
      check("rclk_deb3",   rclk_b,   exp_rclk(m_t));
      check("busy_deb3",   busy_b,   m_t >= 0);
      check("fdone_deb3",  fd_b,     m_t == P - 1);
      check("dchg_deb3",   dc_b,     m_dc[1]);
      check("raw_deb3",    raw_b,    m_raw);
      check("data_deb3",   data_b,   m_data[1]);
      if (fd_a) begin fd_cnt++; fd_cyc = cyc; end
      if (dc_a) dc_a_cnt++;
      if (dc_b) dc_b_cnt++;
      if (rclk_a && !prev_rclk) rise_cnt++;
      prev_rclk = rclk_a;
      if (!sh_ldn_a) ldn_low_cnt++;
    end
  end

  task automatic wait_frame(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      seen = fd_a;
    end
    check({name, "_frame_seen"}, seen, 1'b1);
  endtask

  task automatic wait_rises(input string name, input int target, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      seen = (rise_cnt >= target);
    end
    check({name, "_rises_seen"}, seen, 1'b1);
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [CB-1:0] seq [7] = '{16'h0000, 16'h0000, 16'h1234, 16'hFFFF, 16'h1234, 16'h1234, 16'h1234};

  initial begin
    int s, f0, d0, db0, r0, l0, prev_fd;
    pat[0] = '0;
    pat[1] = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // 1: idle stays quiet
    f0 = fd_cnt; d0 = dc_a_cnt; l0 = ldn_low_cnt;
    repeat (100) @(negedge clk);
    #1;
    check("t1_sh_ldn", sh_ldn_a, 1'b1);
    check("t1_rclk", rclk_a, 1'b0);
    check("t1_busy", busy_a, 1'b0);
    check("t1_data", data_a, 32'h0);
    check("t1_no_frames", fd_cnt - f0, 0);
    check("t1_no_changes", dc_a_cnt - d0, 0);
    check("t1_no_load", ldn_low_cnt - l0, 0);

    // 2: one-shot frame; frame_done lands in cycle 69 counting start's cycle as 0
    pat[0] = 16'hA5C3;
    pat[1] = 16'h0F0F;
    @(negedge clk); #1;
    s = cyc; r0 = rise_cnt; l0 = ldn_low_cnt;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_frame("t2", 200);
    check("t2_done_cycle", fd_cyc - s, 69);
    check("t2_load_cycles", ldn_low_cnt - l0, 4);
    check("t2_rclk_rises", rise_cnt - r0, 16);
    check("t2_raw", raw_a, 32'h0F0FA5C3);
    check("t2_data", data_a, 32'h0F0FA5C3);
    check("t2_changed", dc_a, 1'b1);
    check("t2_data_deb3", data_b, 32'h0);
    @(negedge clk); #1;
    check("t2_idle_busy", busy_a, 1'b0);

    // 3: continuous with glitch frame, debounce 3
    pat[0] = seq[0];
    pat[1] = seq[0];
    db0 = dc_b_cnt;
    prev_fd = 0;
    cont_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wait_frame("t3", 200);
      if (k > 0) check("t3_period", fd_cyc - prev_fd, 69);
      prev_fd = fd_cyc;
      if (k == 3) check("t3_glitch_ignored", data_b, 32'h0);
      if (k == 5) check("t3_two_of_three", data_b, 32'h0);
      if (k == 6) begin
        check("t3_data_deb3", data_b, 32'h12341234);
        check("t3_changed_deb3", dc_b, 1'b1);
        check("t3_data_deb1", data_a, 32'h12341234);
      end
      if (k < 6) begin
        pat[0] = seq[k+1];
        pat[1] = seq[k+1];
      end else begin
        cont_en = 1'b0;
      end
    end
    check("t3_single_change", dc_b_cnt - db0, 1);

    // 4: drop cont_en mid-shift
    @(negedge clk); #1;
    pat[0] = 16'h5A5A;
    pat[1] = 16'h00FF;
    r0 = rise_cnt;
    cont_en = 1'b1;
    wait_rises("t4", r0 + 5, 200);
    cont_en = 1'b0;
    wait_frame("t4", 200);
    check("t4_raw", raw_a, 32'h00FF5A5A);
    @(negedge clk); #1;
    check("t4_busy_falls", busy_a, 1'b0);
    l0 = ldn_low_cnt; f0 = fd_cnt;
    repeat (100) @(negedge clk);
    #1;
    check("t4_no_reload", ldn_low_cnt - l0, 0);
    check("t4_no_frame", fd_cnt - f0, 0);

    // 5: reset in the middle of a shift
    pat[0] = 16'hC001;
    pat[1] = 16'h8000;
    r0 = rise_cnt;
    pulse_start();
    wait_rises("t5", r0 + 9, 200);
    f0 = fd_cnt;
    reset = 1'b1;
    #1;
    check("t5_rst_sh_ldn", sh_ldn_a, 1'b1);
    check("t5_rst_rclk", rclk_a, 1'b0);
    check("t5_rst_busy", busy_a, 1'b0);
    check("t5_rst_raw", raw_a, 32'h0);
    check("t5_rst_data", data_a, 32'h0);
    check("t5_rst_fdone", fd_a, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("t5_no_aborted_frame", fd_cnt - f0, 0);
    pulse_start();
    wait_frame("t5", 200);
    check("t5_raw", raw_a, 32'h8000C001);
    check("t5_data", data_a, 32'h8000C001);
    check("t5_changed", dc_a, 1'b1);

    // 6: start hammered while busy, identical frame repeated
    @(negedge clk); #1;
    f0 = fd_cnt; d0 = dc_a_cnt; db0 = dc_b_cnt;
    s = cyc;
    start = 1'b1;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk); #1;
      start = (i % 5 == 0) && (i < 60);
    end
    check("t6_one_frame", fd_cnt - f0, 1);
    check("t6_done_cycle", fd_cyc - s, 69);
    check("t6_no_change_deb1", dc_a_cnt - d0, 0);
    check("t6_no_change_deb3", dc_b_cnt - db0, 0);
    check("t6_data", data_a, 32'h8000C001);
    check("t6_idle", busy_a, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
